// File: rtl/key_voice_allocator.sv
// Polyphony scheduler: turns key-bitmap edges into press/release events and
// maps pressed keys onto NUM_VOICES voice slots with oldest-voice stealing.
module key_voice_allocator #(
    parameter int NUM_KEYS   = 32,
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 5
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_KEYS-1:0]         i_key,
    input  logic                        i_sustain,
    output logic [NUM_VOICES-1:0]       o_voice_gate,
    output logic [NUM_VOICES*KEY_W-1:0] o_voice_key,
    output logic [NUM_VOICES-1:0]       o_voice_trig,
    output logic [NUM_VOICES-1:0]       o_voice_rel,
    output logic                        o_steal,
    output logic                        o_pending
);

    localparam int RW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {
        V_FREE = 2'd0,
        V_HELD = 2'd1,
        V_SUS  = 2'd2
    } vstate_e;

    logic [NUM_KEYS-1:0] key_q, key_qq;
    logic                sus_q, sus_qq;
    logic [NUM_KEYS-1:0] pend_rel, pend_press;

    vstate_e          vstate   [NUM_VOICES];
    vstate_e          vstate_n [NUM_VOICES];
    logic [KEY_W-1:0] vkey     [NUM_VOICES];
    logic [KEY_W-1:0] vkey_n   [NUM_VOICES];
    logic [RW-1:0]    vrank    [NUM_VOICES];
    logic [RW-1:0]    vrank_n  [NUM_VOICES];

    logic [NUM_KEYS-1:0]   rel_set, prs_set, rel_clr, prs_clr;
    logic [NUM_KEYS-1:0]   pend_rel_n, pend_press_n;
    logic                  sus_fall;
    logic                  rel_any, prs_any;
    logic [KEY_W-1:0]      rel_idx, prs_idx;
    logic [NUM_VOICES-1:0] trig_n, rel_n;
    logic                  steal_n;

    logic          hit_found, free_found, sus_found, held_found;
    logic [RW-1:0] hit_v, free_v, sus_v, held_v, sus_rank, held_rank;
    logic [RW-1:0] sel_v, sel_rank;
    logic          sel_steal;

    assign rel_set  = pend_rel | (~key_q & key_qq);
    assign prs_set  = (pend_press | (key_q & ~key_qq)) & key_q;
    assign sus_fall = ~sus_q & sus_qq;

    always_comb begin
        rel_any = 1'b0;
        rel_idx = '0;
        prs_any = 1'b0;
        prs_idx = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (rel_set[k] && !rel_any) begin
                rel_any = 1'b1;
                rel_idx = KEY_W'(k);
            end
            if (prs_set[k] && !prs_any) begin
                prs_any = 1'b1;
                prs_idx = KEY_W'(k);
            end
        end
    end

    // Voice choice for the candidate press: retrigger > lowest free > oldest sustained > oldest held
    always_comb begin
        hit_found  = 1'b0;
        hit_v      = '0;
        free_found = 1'b0;
        free_v     = '0;
        sus_found  = 1'b0;
        sus_v      = '0;
        sus_rank   = '0;
        held_found = 1'b0;
        held_v     = '0;
        held_rank  = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (vstate[v] != V_FREE && vkey[v] == prs_idx && !hit_found) begin
                hit_found = 1'b1;
                hit_v     = RW'(v);
            end
            if (vstate[v] == V_FREE && !free_found) begin
                free_found = 1'b1;
                free_v     = RW'(v);
            end
            if (vstate[v] == V_SUS && (!sus_found || vrank[v] > sus_rank)) begin
                sus_found = 1'b1;
                sus_v     = RW'(v);
                sus_rank  = vrank[v];
            end
            if (vstate[v] == V_HELD && (!held_found || vrank[v] > held_rank)) begin
                held_found = 1'b1;
                held_v     = RW'(v);
                held_rank  = vrank[v];
            end
        end
        sel_steal = 1'b0;
        if (hit_found) begin
            sel_v = hit_v;
        end else if (free_found) begin
            sel_v = free_v;
        end else if (sus_found) begin
            sel_v     = sus_v;
            sel_steal = 1'b1;
        end else begin
            sel_v     = held_v;
            sel_steal = 1'b1;
        end
        sel_rank = vrank[sel_v];
    end

    always_comb begin
        vstate_n = vstate;
        vkey_n   = vkey;
        vrank_n  = vrank;
        trig_n   = '0;
        rel_n    = '0;
        steal_n  = 1'b0;
        rel_clr  = '0;
        prs_clr  = '0;
        if (sus_fall) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (vstate[v] == V_SUS) begin
                    vstate_n[v] = V_FREE;
                    rel_n[v]    = 1'b1;
                end
            end
        end else if (rel_any) begin
            rel_clr[rel_idx] = 1'b1;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (vstate[v] == V_HELD && vkey[v] == rel_idx) begin
                    if (sus_q) begin
                        vstate_n[v] = V_SUS;
                    end else begin
                        vstate_n[v] = V_FREE;
                        rel_n[v]    = 1'b1;
                    end
                end
            end
        end else if (prs_any) begin
            prs_clr[prs_idx] = 1'b1;
            steal_n          = sel_steal;
            vstate_n[sel_v]  = V_HELD;
            vkey_n[sel_v]    = prs_idx;
            trig_n[sel_v]    = 1'b1;
            // Selected voice becomes newest; everything newer than it ages by one
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (RW'(v) == sel_v) begin
                    vrank_n[v] = '0;
                end else if (vrank[v] < sel_rank) begin
                    vrank_n[v] = vrank[v] + 1'b1;
                end
            end
        end
        pend_rel_n   = rel_set & ~rel_clr;
        pend_press_n = prs_set & ~prs_clr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            key_q        <= '0;
            key_qq       <= '0;
            sus_q        <= 1'b0;
            sus_qq       <= 1'b0;
            pend_rel     <= '0;
            pend_press   <= '0;
            o_voice_trig <= '0;
            o_voice_rel  <= '0;
            o_steal      <= 1'b0;
            o_pending    <= 1'b0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                vstate[v] <= V_FREE;
                vkey[v]   <= '0;
                vrank[v]  <= RW'(v);
            end
        end else begin
            key_q        <= i_key;
            key_qq       <= key_q;
            sus_q        <= i_sustain;
            sus_qq       <= sus_q;
            pend_rel     <= pend_rel_n;
            pend_press   <= pend_press_n;
            o_voice_trig <= trig_n;
            o_voice_rel  <= rel_n;
            o_steal      <= steal_n;
            o_pending    <= |pend_rel_n | |pend_press_n;
            vstate       <= vstate_n;
            vkey         <= vkey_n;
            vrank        <= vrank_n;
        end
    end

    always_comb begin
        o_voice_gate = '0;
        o_voice_key  = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            o_voice_gate[v]                = (vstate[v] != V_FREE);
            o_voice_key[v*KEY_W +: KEY_W]  = vkey[v];
        end
    end

endmodule

// File: tb/tb_key_voice_allocator.sv
// Self-checking bench for key_voice_allocator: directed scenarios plus a
// randomized run against an age-queue reference model.
module tb_key_voice_allocator;

    localparam int NK = 32;
    localparam int NV = 4;
    localparam int KW = 5;

    logic             clk;
    logic             rst_n;
    logic [NK-1:0]    i_key;
    logic             i_sustain;
    logic [NV-1:0]    o_voice_gate;
    logic [NV*KW-1:0] o_voice_key;
    logic [NV-1:0]    o_voice_trig;
    logic [NV-1:0]    o_voice_rel;
    logic             o_steal;
    logic             o_pending;

    int checks = 0;
    int errors = 0;

    key_voice_allocator #(
        .NUM_KEYS   (NK),
        .NUM_VOICES (NV),
        .KEY_W      (KW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_key        (i_key),
        .i_sustain    (i_sustain),
        .o_voice_gate (o_voice_gate),
        .o_voice_key  (o_voice_key),
        .o_voice_trig (o_voice_trig),
        .o_voice_rel  (o_voice_rel),
        .o_steal      (o_steal),
        .o_pending    (o_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: voice states 0=free 1=held 2=sustained; age queue front = newest
    logic [NK-1:0]    m_kq, m_kqq, m_prel, m_pprs;
    logic             m_sq, m_sqq;
    int               m_state [NV];
    int               m_key   [NV];
    int               age [$];
    logic [NV-1:0]    e_gate, e_trig, e_rel;
    logic             e_steal, e_pend;
    logic [NV*KW-1:0] e_key;

    function automatic logic [NK-1:0] kb(input int k);
        logic [NK-1:0] one;
        one = 1;
        return one << k;
    endfunction

    function automatic int lowest(input logic [NK-1:0] s);
        for (int i = 0; i < NK; i++) if (s[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_kq = '0; m_kqq = '0; m_prel = '0; m_pprs = '0;
        m_sq = 1'b0; m_sqq = 1'b0;
        age.delete();
        for (int v = 0; v < NV; v++) begin
            m_state[v] = 0;
            m_key[v]   = 0;
            age.push_back(v);
        end
    endtask

    task automatic model_step(input logic [NK-1:0] k, input logic s);
        logic [NK-1:0] rs, ps;
        int kk, sel;
        e_trig = '0; e_rel = '0; e_steal = 1'b0;
        rs = m_prel | (~m_kq & m_kqq);
        ps = (m_pprs | (m_kq & ~m_kqq)) & m_kq;
        if (!m_sq && m_sqq) begin
            for (int v = 0; v < NV; v++) begin
                if (m_state[v] == 2) begin
                    m_state[v] = 0;
                    e_rel[v]   = 1'b1;
                end
            end
        end else if (rs != '0) begin
            kk = lowest(rs);
            rs[kk] = 1'b0;
            for (int v = 0; v < NV; v++) begin
                if (m_state[v] == 1 && m_key[v] == kk) begin
                    m_state[v] = m_sq ? 2 : 0;
                    if (!m_sq) e_rel[v] = 1'b1;
                end
            end
        end else if (ps != '0) begin
            kk = lowest(ps);
            ps[kk] = 1'b0;
            sel = -1;
            for (int v = 0; v < NV; v++) if (sel < 0 && m_state[v] != 0 && m_key[v] == kk) sel = v;
            for (int v = 0; v < NV; v++) if (sel < 0 && m_state[v] == 0) sel = v;
            if (sel < 0) begin
                e_steal = 1'b1;
                for (int j = age.size() - 1; j >= 0; j--) if (sel < 0 && m_state[age[j]] == 2) sel = age[j];
                if (sel < 0) sel = age[age.size() - 1];
            end
            m_state[sel] = 1;
            m_key[sel]   = kk;
            e_trig[sel]  = 1'b1;
            for (int j = 0; j < age.size(); j++) begin
                if (age[j] == sel) begin
                    age.delete(j);
                    break;
                end
            end
            age.push_front(sel);
        end
        m_prel = rs;
        m_pprs = ps;
        e_pend = (rs | ps) != '0;
        for (int v = 0; v < NV; v++) begin
            e_gate[v]         = (m_state[v] != 0);
            e_key[v*KW +: KW] = m_key[v][KW-1:0];
        end
        m_kqq = m_kq; m_kq = k; m_sqq = m_sq; m_sq = s;
    endtask

    task automatic tick(input logic [NK-1:0] k, input logic s);
        i_key     = k;
        i_sustain = s;
        @(posedge clk);
        model_step(k, s);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_key = '0; i_sustain = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({o_voice_gate, o_voice_key, o_voice_trig, o_voice_rel, o_steal, o_pending} !== '0) begin
            errors++;
            $display("FAIL reset_in: got gate=%b key=%h trig=%b rel=%b steal=%b pend=%b expected all 0",
                     o_voice_gate, o_voice_key, o_voice_trig, o_voice_rel, o_steal, o_pending);
        end
        rst_n = 1'b1;
        idle(3);
        checks++;
        if ({o_voice_gate, o_voice_key, o_voice_trig, o_voice_rel, o_steal, o_pending} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got gate=%b key=%h pend=%b expected all 0", o_voice_gate, o_voice_key, o_pending);
        end
    endtask

    task automatic test_single();
        tick(kb(5), 1'b0);
        checks++;
        if (o_voice_trig !== 4'b0000) begin
            errors++; $display("FAIL single_early: got trig=%b expected 0000", o_voice_trig);
        end
        tick(kb(5), 1'b0);
        checks++;
        if (o_voice_gate !== 4'b0001 || o_voice_trig !== 4'b0001 || o_voice_key[4:0] !== 5'd5) begin
            errors++;
            $display("FAIL single_press: got gate=%b trig=%b key0=%0d expected 0001 0001 5", o_voice_gate, o_voice_trig, o_voice_key[4:0]);
        end
        tick(kb(5), 1'b0);
        checks++;
        if (o_voice_trig !== 4'b0000 || o_voice_gate !== 4'b0001) begin
            errors++; $display("FAIL single_pulse: got trig=%b gate=%b expected 0000 0001", o_voice_trig, o_voice_gate);
        end
        tick('0, 1'b0);
        tick('0, 1'b0);
        checks++;
        if (o_voice_rel !== 4'b0001 || o_voice_gate !== 4'b0000) begin
            errors++; $display("FAIL single_release: got rel=%b gate=%b expected 0001 0000", o_voice_rel, o_voice_gate);
        end
        idle(2);
    endtask

    task automatic test_steal_oldest();
        tick(32'h2, 1'b0);
        tick(32'h6, 1'b0);
        tick(32'hE, 1'b0);
        tick(32'h1E, 1'b0);
        tick(32'h1E, 1'b0);
        checks++;
        if (o_voice_gate !== 4'b1111 || o_voice_key !== {5'd4, 5'd3, 5'd2, 5'd1}) begin
            errors++; $display("FAIL steal_fill: got gate=%b key=%h expected 1111 %h", o_voice_gate, o_voice_key, {5'd4, 5'd3, 5'd2, 5'd1});
        end
        tick(32'h5E, 1'b0);
        tick(32'h5E, 1'b0);
        checks++;
        if (o_voice_key[4:0] !== 5'd6 || o_voice_trig !== 4'b0001 || o_steal !== 1'b1 || o_voice_rel !== 4'b0000) begin
            errors++;
            $display("FAIL steal_oldest: got key0=%0d trig=%b steal=%b rel=%b expected 6 0001 1 0000", o_voice_key[4:0], o_voice_trig, o_steal, o_voice_rel);
        end
        tick('0, 1'b0);
        idle(8);
        checks++;
        if (o_voice_gate !== 4'b0000 || o_pending !== 1'b0) begin
            errors++; $display("FAIL steal_cleanup: got gate=%b pend=%b expected 0000 0", o_voice_gate, o_pending);
        end
    endtask

    task automatic test_back_to_back();
        tick(32'h6, 1'b0);
        tick(32'h6, 1'b0);
        checks++;
        if (o_voice_trig !== 4'b0001 || o_voice_key[4:0] !== 5'd1 || o_pending !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got trig=%b key0=%0d pend=%b expected 0001 1 1", o_voice_trig, o_voice_key[4:0], o_pending);
        end
        tick(32'h6, 1'b0);
        checks++;
        if (o_voice_trig !== 4'b0010 || o_voice_key[9:5] !== 5'd2 || o_pending !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got trig=%b key1=%0d pend=%b expected 0010 2 0", o_voice_trig, o_voice_key[9:5], o_pending);
        end
        tick('0, 1'b0);
        idle(4);
    endtask

    task automatic test_sustain();
        tick('0, 1'b1);
        tick('0, 1'b1);
        checks++;
        if (o_voice_gate !== 4'b0000 || o_voice_trig !== 4'b0000 || o_voice_rel !== 4'b0000) begin
            errors++; $display("FAIL sus_rise: got gate=%b trig=%b rel=%b expected all 0000", o_voice_gate, o_voice_trig, o_voice_rel);
        end
        tick(kb(3), 1'b1);
        tick(kb(3), 1'b1);
        checks++;
        if (o_voice_trig !== 4'b0001 || o_voice_key[4:0] !== 5'd3) begin
            errors++; $display("FAIL sus_press: got trig=%b key0=%0d expected 0001 3", o_voice_trig, o_voice_key[4:0]);
        end
        tick('0, 1'b1);
        tick('0, 1'b1);
        checks++;
        if (o_voice_gate !== 4'b0001 || o_voice_rel !== 4'b0000) begin
            errors++; $display("FAIL sus_hold: got gate=%b rel=%b expected 0001 0000", o_voice_gate, o_voice_rel);
        end
        tick(kb(3), 1'b1);
        tick(kb(3), 1'b1);
        checks++;
        if (o_voice_trig !== 4'b0001 || o_voice_gate !== 4'b0001 || o_steal !== 1'b0) begin
            errors++; $display("FAIL sus_retrig: got trig=%b gate=%b steal=%b expected 0001 0001 0", o_voice_trig, o_voice_gate, o_steal);
        end
        tick('0, 1'b1);
        tick('0, 1'b1);
        tick('0, 1'b0);
        tick('0, 1'b0);
        checks++;
        if (o_voice_rel !== 4'b0001 || o_voice_gate !== 4'b0000) begin
            errors++; $display("FAIL sus_fall: got rel=%b gate=%b expected 0001 0000", o_voice_rel, o_voice_gate);
        end
        idle(2);
    endtask

    task automatic test_steal_sustained();
        logic [NK-1:0] k;
        k = '0;
        for (int i = 10; i <= 13; i++) begin
            k = k | kb(i);
            tick(k, 1'b1);
        end
        tick(k, 1'b1);
        k = k & ~kb(13);
        tick(k, 1'b1);
        tick(k, 1'b1);
        checks++;
        if (o_voice_gate !== 4'b1111 || o_voice_rel !== 4'b0000) begin
            errors++; $display("FAIL stsus_setup: got gate=%b rel=%b expected 1111 0000", o_voice_gate, o_voice_rel);
        end
        k = k | kb(14);
        tick(k, 1'b1);
        tick(k, 1'b1);
        checks++;
        if (o_voice_trig !== 4'b1000 || o_voice_key[19:15] !== 5'd14 || o_steal !== 1'b1 || o_voice_key[4:0] !== 5'd10) begin
            errors++;
            $display("FAIL stsus_steal: got trig=%b key3=%0d steal=%b key0=%0d expected 1000 14 1 10",
                     o_voice_trig, o_voice_key[19:15], o_steal, o_voice_key[4:0]);
        end
        tick('0, 1'b0);
        idle(8);
    endtask

    task automatic test_mid_reset();
        tick(kb(7), 1'b0);
        tick(kb(7), 1'b0);
        checks++;
        if (o_voice_gate !== 4'b0001 || o_voice_trig !== 4'b0001) begin
            errors++; $display("FAIL mrst_pre: got gate=%b trig=%b expected 0001 0001", o_voice_gate, o_voice_trig);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_voice_gate, o_voice_key, o_voice_trig, o_voice_rel, o_steal, o_pending} !== '0) begin
            errors++; $display("FAIL mrst_async: got gate=%b key=%h trig=%b expected all 0", o_voice_gate, o_voice_key, o_voice_trig);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        tick(kb(7), 1'b0);
        checks++;
        if (o_voice_trig !== 4'b0000) begin
            errors++; $display("FAIL mrst_early: got trig=%b expected 0000", o_voice_trig);
        end
        tick(kb(7), 1'b0);
        checks++;
        if (o_voice_trig !== 4'b0001 || o_voice_key[4:0] !== 5'd7) begin
            errors++; $display("FAIL mrst_redetect: got trig=%b key0=%0d expected 0001 7", o_voice_trig, o_voice_key[4:0]);
        end
        tick('0, 1'b0);
        idle(3);
    endtask

    task automatic test_random();
        logic [NK-1:0] cur;
        logic          sus;
        int            r, b;
        cur = '0;
        sus = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n >= 2960) begin
                cur = '0;
                sus = 1'b0;
            end else begin
                r = int'($urandom_range(0, 15));
                if (r < 5) begin
                    b = (r == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 9));
                    cur[b] = ~cur[b];
                end
                if ($urandom_range(0, 19) == 0) sus = ~sus;
            end
            tick(cur, sus);
            checks++;
            if (o_voice_gate !== e_gate) begin
                errors++; $display("FAIL rnd_gate @%0d: got %b expected %b", n, o_voice_gate, e_gate);
            end
            checks++;
            if (o_voice_key !== e_key) begin
                errors++; $display("FAIL rnd_key @%0d: got %h expected %h", n, o_voice_key, e_key);
            end
            checks++;
            if (o_voice_trig !== e_trig) begin
                errors++; $display("FAIL rnd_trig @%0d: got %b expected %b", n, o_voice_trig, e_trig);
            end
            checks++;
            if (o_voice_rel !== e_rel) begin
                errors++; $display("FAIL rnd_rel @%0d: got %b expected %b", n, o_voice_rel, e_rel);
            end
            checks++;
            if (o_steal !== e_steal) begin
                errors++; $display("FAIL rnd_steal @%0d: got %b expected %b", n, o_steal, e_steal);
            end
            checks++;
            if (o_pending !== e_pend) begin
                errors++; $display("FAIL rnd_pending @%0d: got %b expected %b", n, o_pending, e_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_steal_oldest();
        test_back_to_back();
        test_sustain();
        test_steal_sustained();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
